// File: rtl/data_mem_io_pkg.sv
// Address map, TXSTAT field layout and address decode shared by data_mem_io and CPU test programs.
// The TX FIFO registers only decode to live hardware when DATA_MEM_IO_TX_FIFO_EN is defined.
package data_mem_io_pkg;

    localparam logic [31:0] ADDR_LED    = 32'hFFFF_FF00;
    localparam logic [31:0] ADDR_CYCLE  = 32'hFFFF_FF04;
    localparam logic [31:0] ADDR_TXDATA = 32'hFFFF_FF08;
    localparam logic [31:0] ADDR_TXSTAT = 32'hFFFF_FF0C;

    localparam int TXSTAT_EMPTY_BIT  = 0;
    localparam int TXSTAT_OVF_BIT    = 1;
    localparam int TXSTAT_COUNT_LSB  = 2;
    localparam int TXSTAT_COUNT_W    = 5;

    typedef struct packed {
        logic [24:0] reserved;
        logic [4:0]  count;
        logic        overflow;
        logic        empty;
    } txstat_t;

    typedef enum logic [2:0] {
        REGION_NONE,
        REGION_RAM,
        REGION_LED,
        REGION_CYCLE,
        REGION_TXDATA,
        REGION_TXSTAT
    } region_t;

    // Word-granular decode: the two byte-offset bits never affect which target is selected.
    function automatic region_t decode_addr(input logic [31:0] addr, input logic [31:0] ram_bytes);
        region_t r;
        r = REGION_NONE;
        if ((addr >> 2) < (ram_bytes >> 2))
            r = REGION_RAM;
        else if (addr[31:2] == ADDR_LED[31:2])
            r = REGION_LED;
        else if (addr[31:2] == ADDR_CYCLE[31:2])
            r = REGION_CYCLE;
        else if (addr[31:2] == ADDR_TXDATA[31:2])
            r = REGION_TXDATA;
        else if (addr[31:2] == ADDR_TXSTAT[31:2])
            r = REGION_TXSTAT;
        return r;
    endfunction

    function automatic logic [31:0] pack_txstat(input logic [4:0] count, input logic overflow,
                                                input logic empty);
        txstat_t s;
        s.reserved = '0;
        s.count    = count;
        s.overflow = overflow;
        s.empty    = empty;
        return s;
    endfunction

endpackage

// File: rtl/data_mem_io_fifo.sv
// sync_fifo: single-clock FIFO with registered pointers and occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_COUNT);
    assign count   = cnt;
    assign dout    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_io.sv
// Data memory and MMIO block for a single-cycle CPU: RAM, LED register, cycle counter and
// an optional host TX FIFO enabled by defining DATA_MEM_IO_TX_FIFO_EN.
module data_mem_io
    import data_mem_io_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] aluout,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0]       ram [RAM_WORDS];
    logic [31:0]       cycle_cnt;
    logic [31:0]       txstat_word;
    logic [RAM_AW-1:0] ram_idx;
    region_t           region;

    assign region  = decode_addr(aluout, RAM_BYTES);
    assign ram_idx = aluout[RAM_AW+1:2];

    // RAM is deliberately left out of reset so program data survives a CPU restart.
    always_ff @(posedge clk) begin
        if (!reset && memwrite && region == REGION_RAM)
            ram[ram_idx] <= writedata;
    end

    always_ff @(posedge clk) begin
        if (reset)
            leds <= '0;
        else if (memwrite && region == REGION_LED)
            leds <= writedata[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset)
            cycle_cnt <= '0;
        else if (memwrite && region == REGION_CYCLE)
            cycle_cnt <= '0;
        else
            cycle_cnt <= cycle_cnt + 32'd1;
    end

`ifdef DATA_MEM_IO_TX_FIFO_EN
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_push;
    logic          fifo_pop;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic          store_txdata;
    logic          store_txstat;
    logic          overflow;

    assign store_txdata = memwrite && region == REGION_TXDATA;
    assign store_txstat = memwrite && region == REGION_TXSTAT;
    assign fifo_pop     = !fifo_empty && tx_ready;
    assign fifo_push    = store_txdata && (!fifo_full || fifo_pop);

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (writedata[7:0]),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Clear is tested before set so software acknowledging overflow always wins.
    always_ff @(posedge clk) begin
        if (reset)
            overflow <= 1'b0;
        else if (store_txstat)
            overflow <= 1'b0;
        else if (store_txdata && fifo_full && !fifo_pop)
            overflow <= 1'b1;
    end

    assign tx_valid    = !fifo_empty;
    assign tx_data     = fifo_head;
    assign txstat_word = pack_txstat(5'(fifo_count), overflow, fifo_empty);
`else
    logic unused_tx_ready;

    assign unused_tx_ready = tx_ready;
    assign tx_valid        = 1'b0;
    assign tx_data         = 8'h00;
    assign txstat_word     = 32'h0;
`endif

    always_comb begin
        readdata = 32'h0;
        case (region)
            REGION_RAM:    readdata = ram[ram_idx];
            REGION_LED:    readdata = {24'h0, leds};
            REGION_CYCLE:  readdata = cycle_cnt;
            REGION_TXSTAT: readdata = txstat_word;
            default:       readdata = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_data_mem_io.sv
// Testbench for data_mem_io: directed scenarios plus randomized traffic against a queue-based model.
// FIFO expectations follow whether DATA_MEM_IO_TX_FIFO_EN is defined for the build.
module tb_data_mem_io;

    localparam int          RAM_WORDS  = 64;
    localparam int          FIFO_DEPTH = 8;
    localparam logic [31:0] A_LED      = 32'hFFFF_FF00;
    localparam logic [31:0] A_CYCLE    = 32'hFFFF_FF04;
    localparam logic [31:0] A_TXDATA   = 32'hFFFF_FF08;
    localparam logic [31:0] A_TXSTAT   = 32'hFFFF_FF0C;
`ifdef DATA_MEM_IO_TX_FIFO_EN
    localparam bit FIFO_EN = 1'b1;
`else
    localparam bit FIFO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_ram [RAM_WORDS];
    bit          m_known [RAM_WORDS];
    logic [7:0]  m_leds;
    logic [31:0] m_cycle;
    logic [7:0]  m_q [$];
    bit          m_ovf;
    logic [7:0]  rx_q [$];

    data_mem_io #(
        .RAM_WORDS  (RAM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .aluout    (aluout),
        .writedata (writedata),
        .readdata  (readdata),
        .leds      (leds),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    // Reference model: what the coming clock edge should do to architectural state.
    task automatic model_update();
        logic [31:0] a;
        int          sz;
        bit          popped;
        a = {aluout[31:2], 2'b00};
        if (reset) begin
            m_leds  = 8'h00;
            m_cycle = 32'h0;
            m_q.delete();
            m_ovf   = 1'b0;
            return;
        end
        sz     = m_q.size();
        popped = FIFO_EN && sz > 0 && tx_ready;
        if (popped)
            void'(m_q.pop_front());
        m_cycle = (memwrite && a == A_CYCLE) ? 32'h0 : m_cycle + 32'd1;
        if (memwrite) begin
            if (a < RAM_WORDS * 4) begin
                m_ram[int'(a >> 2)]   = writedata;
                m_known[int'(a >> 2)] = 1'b1;
            end else if (a == A_LED) begin
                m_leds = writedata[7:0];
            end else if (FIFO_EN && a == A_TXDATA) begin
                if (sz < FIFO_DEPTH || popped)
                    m_q.push_back(writedata[7:0]);
                else
                    m_ovf = 1'b1;
            end else if (FIFO_EN && a == A_TXSTAT) begin
                m_ovf = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        logic [31:0] a;
        a = {addr[31:2], 2'b00};
        if (a < RAM_WORDS * 4)
            return m_ram[int'(a >> 2)];
        if (a == A_LED)
            return {24'h0, m_leds};
        if (a == A_CYCLE)
            return m_cycle;
        if (FIFO_EN && a == A_TXSTAT)
            return 32'(m_q.size() * 4 + (m_ovf ? 2 : 0) + (m_q.size() == 0 ? 1 : 0));
        return 32'h0;
    endfunction

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        memwrite  = 1'b1;
        aluout    = addr;
        writedata = data;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        memwrite = 1'b0;
        tick();
        reset    = 1'b0;
    endtask

    task automatic drain();
        rx_q.delete();
        tx_ready = 1'b1;
        for (int n = 0; n < 3 * FIFO_DEPTH; n++) begin
            if (!tx_valid)
                break;
            rx_q.push_back(tx_data);
            tick();
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; memwrite = 1'b1; aluout = A_LED; writedata = 32'hFF;
        tick();
        reset = 1'b0; memwrite = 1'b0;
        checks++; if (leds !== 8'h00) begin errors++; $display("FAIL reset_leds: got %h expected 00", leds); end
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        aluout = A_CYCLE; #1;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_cycle: got %h expected 0", readdata); end
        aluout = A_TXSTAT; #1;
        checks++; if (readdata !== {31'h0, FIFO_EN}) begin errors++; $display("FAIL reset_txstat: got %h expected %h", readdata, {31'h0, FIFO_EN}); end
    endtask

    task automatic test_ram();
        store(32'h10, 32'hDEADBEEF);
        aluout = 32'h10; #1;
        checks++; if (readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_load_10: got %h expected deadbeef", readdata); end
        aluout = 32'h12; #1;
        checks++; if (readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_load_12: got %h expected deadbeef", readdata); end
        memwrite = 1'b1; aluout = 32'h10; writedata = 32'h1234_5678; #1;
        checks++; if (readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rdw_old: got %h expected deadbeef", readdata); end
        tick();
        memwrite = 1'b0; #1;
        checks++; if (readdata !== 32'h1234_5678) begin errors++; $display("FAIL ram_new_word: got %h expected 12345678", readdata); end
        store(32'h10, 32'hDEADBEEF);
    endtask

    task automatic test_unmapped_led();
        store(32'h0, 32'h1111_1111);
        aluout = 32'h1000; #1;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL unmapped_load: got %h expected 0", readdata); end
        store(32'h1000, 32'hCAFE_F00D);
        aluout = 32'h0; #1;
        checks++; if (readdata !== 32'h1111_1111) begin errors++; $display("FAIL unmapped_store_alias: got %h expected 11111111", readdata); end
        store(A_LED, 32'h1A5);
        checks++; if (leds !== 8'hA5) begin errors++; $display("FAIL led_store: got %h expected a5", leds); end
        aluout = A_LED; #1;
        checks++; if (readdata !== 32'hA5) begin errors++; $display("FAIL led_load: got %h expected a5", readdata); end
    endtask

    task automatic test_cycle();
        do_reset();
        for (int i = 0; i < 10; i++)
            tick();
        aluout = A_CYCLE; #1;
        checks++; if (readdata !== 32'd10) begin errors++; $display("FAIL cycle_after_10: got %0d expected 10", readdata); end
        store(A_CYCLE, 32'hFFFF);
        aluout = A_CYCLE; #1;
        checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL cycle_cleared: got %0d expected 0", readdata); end
        tick();
        checks++; if (readdata !== 32'd1) begin errors++; $display("FAIL cycle_next: got %0d expected 1", readdata); end
    endtask

`ifdef DATA_MEM_IO_TX_FIFO_EN
    task automatic test_fifo_fill();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            store(A_TXDATA, 32'(32'h41 + i));
        aluout = A_TXSTAT; #1;
        checks++; if (readdata !== 32'h20) begin errors++; $display("FAIL fill_txstat: got %h expected 20", readdata); end
        aluout = A_TXDATA; #1;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h expected 0", readdata); end
        store(A_TXDATA, 32'h49);
        aluout = A_TXSTAT; #1;
        checks++; if (readdata !== 32'h22) begin errors++; $display("FAIL overflow_txstat: got %h expected 22", readdata); end
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL head_byte: got %h expected 41", tx_data); end
        drain();
        checks++; if (rx_q.size() != 8) begin errors++; $display("FAIL fill_drain_count: got %0d expected 8", rx_q.size()); end
        for (int i = 0; i < rx_q.size(); i++) begin
            checks++; if (rx_q[i] !== 8'(8'h41 + i)) begin errors++; $display("FAIL fill_order[%0d]: got %h expected %h", i, rx_q[i], 8'(8'h41 + i)); end
        end
        store(A_TXSTAT, 32'h0);
        aluout = A_TXSTAT; #1;
        checks++; if (readdata !== 32'h01) begin errors++; $display("FAIL overflow_clear: got %h expected 01", readdata); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            store(A_TXDATA, 32'(32'h41 + i));
        tx_ready = 1'b1;
        store(A_TXDATA, 32'h5A);
        tx_ready = 1'b0;
        aluout = A_TXSTAT; #1;
        checks++; if (readdata !== 32'h20) begin errors++; $display("FAIL full_push_pop_txstat: got %h expected 20", readdata); end
        drain();
        checks++; if (rx_q.size() != 8) begin errors++; $display("FAIL full_push_pop_count: got %0d expected 8", rx_q.size()); end
        checks++; if (rx_q.size() > 0 && rx_q[rx_q.size()-1] !== 8'h5A) begin errors++; $display("FAIL full_push_pop_last: got %h expected 5a", rx_q[rx_q.size()-1]); end
        checks++; if (rx_q.size() > 0 && rx_q[0] !== 8'h42) begin errors++; $display("FAIL full_push_pop_first: got %h expected 42", rx_q[0]); end
    endtask

    task automatic test_reset_fifo();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            store(A_TXDATA, 32'(32'h61 + i));
        aluout = A_TXSTAT; #1;
        checks++; if (readdata !== 32'h0C) begin errors++; $display("FAIL three_txstat: got %h expected 0c", readdata); end
        do_reset();
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_fifo_valid: got %b expected 0", tx_valid); end
        aluout = A_TXSTAT; #1;
        checks++; if (readdata !== 32'h01) begin errors++; $display("FAIL reset_fifo_txstat: got %h expected 01", readdata); end
        aluout = 32'h10; #1;
        checks++; if (readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_keeps_ram: got %h expected deadbeef", readdata); end
    endtask
`else
    task automatic test_tx_disabled();
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            store(A_TXDATA, 32'(32'h61 + i));
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL disabled_tx_valid: got %b expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL disabled_tx_data: got %h expected 00", tx_data); end
        aluout = A_TXSTAT; #1;
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL disabled_txstat: got %h expected 0", readdata); end
        do_reset();
        aluout = 32'h10; #1;
        checks++; if (readdata !== 32'hDEADBEEF) begin errors++; $display("FAIL reset_keeps_ram: got %h expected deadbeef", readdata); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] exp;
        logic [31:0] a;
        int          sel;
        bit          ram_hit;
        store(A_TXSTAT, 32'h0);
        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                5:       a = A_LED;
                6:       a = A_CYCLE;
                7:       a = A_TXDATA;
                8:       a = A_TXSTAT;
                9: begin
                    case ($urandom_range(0, 3))
                        0:       a = 32'h0000_0100;
                        1:       a = 32'h0000_1000;
                        2:       a = 32'hFFFF_FF10;
                        default: a = 32'h8000_0004;
                    endcase
                end
                default: a = 32'($urandom_range(0, RAM_WORDS - 1) * 4);
            endcase
            aluout    = {a[31:2], 2'($urandom_range(0, 3))};
            memwrite  = ($urandom_range(0, 1) == 1);
            writedata = $urandom;
            tx_ready  = ($urandom_range(0, 2) == 0);
            #1;
            ram_hit = (a < RAM_WORDS * 4);
            exp     = model_read(aluout);
            if (!ram_hit || m_known[int'(a >> 2)]) begin
                checks++; if (readdata !== exp) begin errors++; $display("[TB] FAIL rand_readdata @%0d addr %h: got %h expected %h", n, aluout, readdata, exp); end
            end
            checks++; if (tx_valid !== (m_q.size() > 0)) begin errors++; $display("[TB] FAIL rand_tx_valid @%0d: got %b expected %b", n, tx_valid, m_q.size() > 0); end
`ifdef DATA_MEM_IO_TX_FIFO_EN
            if (m_q.size() > 0) begin
                checks++; if (tx_data !== m_q[0]) begin errors++; $display("[TB] FAIL rand_tx_data @%0d: got %h expected %h", n, tx_data, m_q[0]); end
            end
`else
            checks++; if (tx_data !== 8'h00) begin errors++; $display("[TB] FAIL rand_tx_data @%0d: got %h expected 00", n, tx_data); end
`endif
            checks++; if (leds !== m_leds) begin errors++; $display("[TB] FAIL rand_leds @%0d: got %h expected %h", n, leds, m_leds); end
            tick();
        end
        memwrite = 1'b0;
        tx_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; memwrite = 1'b0; aluout = 32'h0; writedata = 32'h0; tx_ready = 1'b0;
        m_leds = 8'h00; m_cycle = 32'h0; m_ovf = 1'b0;
        for (int i = 0; i < RAM_WORDS; i++) m_known[i] = 1'b0;
        @(negedge clk);
        test_reset();
        test_ram();
        test_unmapped_led();
        test_cycle();
`ifdef DATA_MEM_IO_TX_FIFO_EN
        test_fifo_fill();
        test_full_push_pop();
        test_reset_fifo();
`else
        test_tx_disabled();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
